// File: rtl/starship_pkg.sv
// Shared definitions for the starship repair controller: global state
// encoding and statistics width.
package starship_pkg;
  typedef logic [2:0] gstate_t;
  localparam gstate_t ST_INIT = 3'b001;
  localparam gstate_t ST_RUN  = 3'b010;
  localparam gstate_t ST_FAIL = 3'b100;
  localparam int REPAIR_CNT_W = 16;
endpackage

// File: rtl/starship_repair_chan.sv
// One subsystem: broken flag, latched repair combo and deadline timer.
// The timer saturates at its last value; the top turns that into FAIL.
module starship_repair_chan #(
  parameter int COMBO_W = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               run,
  input  logic               clr_all,
  input  logic               brk_acc,
  input  logic               fix,
  input  logic [COMBO_W-1:0] combo_in,
  output logic               broken,
  output logic [COMBO_W-1:0] combo,
  output logic               timeout
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] timer;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      broken <= 1'b0;
      combo  <= '0;
      timer  <= '0;
    end else if (clr_all) begin
      broken <= 1'b0;
      combo  <= '0;
      timer  <= '0;
    end else if (run) begin
      if (fix) begin
        broken <= 1'b0;
        timer  <= '0;
      end else if (brk_acc) begin
        broken <= 1'b1;
        combo  <= combo_in;
        timer  <= '0;
      end else if (broken && timer != T_LAST) begin
        timer <= timer + 1'b1;
      end
    end
  end

  // A fix landing on the deadline edge still saves the channel.
  assign timeout = broken & (timer == T_LAST) & ~fix;
endmodule

// File: rtl/starship_repair_bank.sv
// Multi-subsystem damage/repair controller: global INIT/RUN/FAIL FSM,
// lowest-index break arbiter, submit decode, popcount and repair stats.
module starship_repair_bank
  import starship_pkg::*;
#(
  parameter int NUM_SYS = 4,
  parameter int COMBO_W = 4,
  parameter int TIMEOUT = 1000,
  localparam int SW = (NUM_SYS > 1) ? $clog2(NUM_SYS) : 1,
  localparam int CW = $clog2(NUM_SYS + 1)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       play_flag,
  input  logic                       gameover_ctrl,
  input  logic [NUM_SYS-1:0]         break_req,
  input  logic [COMBO_W-1:0]         random_combo,
  input  logic [COMBO_W-1:0]         hex_combo,
  input  logic                       submit,
  input  logic [SW-1:0]              sel,
  input  logic [NUM_SYS-1:0]         force_fix,
  output logic                       q_init,
  output logic                       q_run,
  output logic                       q_fail,
  output logic [NUM_SYS-1:0]         broken,
  output logic [NUM_SYS*COMBO_W-1:0] repair_combo,
  output logic [CW-1:0]              broken_count,
  output logic                       repair_ok,
  output logic                       repair_bad,
  output logic                       fail_pulse,
  output logic [REPAIR_CNT_W-1:0]    repair_cnt
);
  gstate_t state, state_nxt;
  logic run, clr_all, fail, any_hit;
  logic [NUM_SYS-1:0] brk_acc, hit, fix, timeout;

  // gameover_ctrl overrides everything, including in-flight repairs.
  assign run     = (state == ST_RUN) && !gameover_ctrl;
  assign clr_all = (state == ST_INIT) || gameover_ctrl;
  assign fail    = run && (|timeout);
  assign any_hit = |hit;
  assign fix     = hit | force_fix;

  always_comb begin
    logic found;
    brk_acc = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SYS; i++) begin
      if (break_req[i] && !broken[i] && !found) begin
        brk_acc[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  // Out-of-range sel never matches any channel, so it decodes as a bad attempt.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SYS; i++)
      hit[i] = submit && (sel == SW'(i)) && broken[i] &&
               (hex_combo == repair_combo[i*COMBO_W +: COMBO_W]);
  end

  always_comb begin
    broken_count = '0;
    for (int i = 0; i < NUM_SYS; i++)
      broken_count = broken_count + CW'(broken[i]);
  end

  generate
    for (genvar g = 0; g < NUM_SYS; g++) begin : gen_chan
      starship_repair_chan #(.COMBO_W(COMBO_W), .TIMEOUT(TIMEOUT)) u_chan (
        .Clk      (Clk),
        .Reset    (Reset),
        .run      (run),
        .clr_all  (clr_all),
        .brk_acc  (brk_acc[g]),
        .fix      (fix[g]),
        .combo_in (random_combo),
        .broken   (broken[g]),
        .combo    (repair_combo[g*COMBO_W +: COMBO_W]),
        .timeout  (timeout[g])
      );
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (!gameover_ctrl && play_flag) state_nxt = ST_RUN;
      ST_RUN: begin
        if (gameover_ctrl) state_nxt = ST_INIT;
        else if (fail)     state_nxt = ST_FAIL;
      end
      ST_FAIL: if (gameover_ctrl) state_nxt = ST_INIT;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    q_init = state[0];
    q_run  = state[1];
    q_fail = state[2];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      repair_ok  <= 1'b0;
      repair_bad <= 1'b0;
      fail_pulse <= 1'b0;
      repair_cnt <= '0;
    end else begin
      repair_ok  <= run && any_hit;
      repair_bad <= run && submit && !any_hit;
      fail_pulse <= fail;
      if (clr_all)
        repair_cnt <= '0;
      else if (run && any_hit && repair_cnt != {REPAIR_CNT_W{1'b1}})
        repair_cnt <= repair_cnt + 1'b1;
    end
  end
endmodule
